// File: rtl/exec_unit.sv
// Execute/writeback stage for the 4x8-bit register file.
// Single-cycle ALU ops write back on the accept edge; shifts and the
// optional shift-add multiplier iterate one bit per cycle and stall issue.
module exec_unit #(
    parameter int DATA_W     = 8,
    parameter int REG_AW     = 2,
    parameter int MUL_ENABLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [2:0]        op,
    input  logic [REG_AW-1:0] rd,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              is_write,
    output logic [REG_AW-1:0] reg_write,
    output logic [DATA_W-1:0] write_val,
    output logic              busy,
    output logic              flag_z,
    output logic              flag_c
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          op_q;
    logic [REG_AW-1:0]   rd_q;
    logic [DATA_W-1:0]   acc;      // shift operand, or multiply partial sum
    logic [DATA_W-1:0]   mcand;    // multiplicand, shifted left each step
    logic [DATA_W-1:0]   mplr;     // multiplier, shifted right each step

    logic                accept;
    logic                start_multi;
    logic [2:0]          shamt;
    logic [DATA_W:0]     single_res;
    logic [DATA_W-1:0]   iter_val;

    // Single-cycle result; bit DATA_W is carry (ADD) or borrow (SUB).
    function automatic logic [DATA_W:0] alu_single(
        input logic [2:0]        f_op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] r;
        case (f_op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_SHL,
            OP_SHR:  r = {1'b0, a};        // only reached with shift amount 0
            default: r = '0;               // MUL with the multiplier disabled
        endcase
        return r;
    endfunction

    // Accept decode and the single-cycle ALU result
    always_comb begin
        issue_ready = (state == IDLE);
        busy        = (state == BUSY);
        accept      = issue_valid && issue_ready;
        shamt       = rt_val[2:0];
        start_multi = 1'b0;
        if ((op == OP_SHL || op == OP_SHR) && shamt != 3'd0)
            start_multi = 1'b1;
        if (op == OP_MUL && MUL_ENABLE != 0)
            start_multi = 1'b1;
        single_res = alu_single(op, rs_val, rt_val);
    end

    // Value the iterative datapath holds after the current BUSY step
    always_comb begin
        iter_val = acc;
        case (op_q)
            OP_SHL:  iter_val = acc << 1;
            OP_SHR:  iter_val = acc >> 1;
            default: iter_val = acc + (mplr[0] ? mcand : '0);
        endcase
    end

    // Control FSM, iteration datapath and registered write-back port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            is_write  <= 1'b0;
            reg_write <= '0;
            write_val <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
        end else begin
            is_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (start_multi) begin
                            state <= BUSY;
                            op_q  <= op;
                            rd_q  <= rd;
                            mcand <= rs_val;
                            mplr  <= rt_val;
                            if (op == OP_MUL) begin
                                cnt <= CNT_W'(DATA_W);
                                acc <= '0;
                            end else begin
                                cnt <= CNT_W'(shamt);
                                acc <= rs_val;
                            end
                        end else begin
                            is_write  <= 1'b1;
                            reg_write <= rd;
                            write_val <= single_res[DATA_W-1:0];
                            flag_z    <= (single_res[DATA_W-1:0] == '0);
                            if (op == OP_ADD || op == OP_SUB)
                                flag_c <= single_res[DATA_W];
                        end
                    end
                end
                BUSY: begin
                    acc   <= iter_val;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= IDLE;
                        is_write  <= 1'b1;
                        reg_write <= rd_q;
                        write_val <= iter_val;
                        flag_z    <= (iter_val == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: a table of single-cycle ops issued
// back-to-back, then hand-written shift, multiply, reset and
// register-file dependency sequences.
module tb_exec_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] op;
    logic [1:0] rd;
    logic [7:0] rs_val;
    logic [7:0] rt_val;
    logic       is_write;
    logic [1:0] reg_write;
    logic [7:0] write_val;
    logic       busy;
    logic       flag_z;
    logic       flag_c;

    logic [7:0] rs_drv;
    logic       use_rf;
    logic [1:0] rs_sel;
    logic [7:0] rf [4];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] val;
        logic       c;
        logic       z;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    exec_unit #(.DATA_W(8), .REG_AW(2), .MUL_ENABLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .op(op), .rd(rd), .rs_val(rs_val), .rt_val(rt_val),
        .is_write(is_write), .reg_write(reg_write), .write_val(write_val),
        .busy(busy), .flag_z(flag_z), .flag_c(flag_c)
    );

    // Register file model: commits on negedge while is_write is high
    assign rs_val = use_rf ? rf[rs_sel] : rs_drv;
    always @(negedge clk) begin
        if (is_write) rf[reg_write] <= write_val;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present an op at negedge; return 1ns after the following posedge
    task automatic issue(input logic [2:0] o, input logic [1:0] d,
                         input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        op = o; rd = d; rs_drv = a; rt_val = b; issue_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " is_write"},    32'(is_write),    32'd0);
        chk({tag, " reg_write"},   32'(reg_write),   32'd0);
        chk({tag, " write_val"},   32'(write_val),   32'd0);
        chk({tag, " busy"},        32'(busy),        32'd0);
        chk({tag, " flag_z"},      32'(flag_z),      32'd0);
        chk({tag, " flag_c"},      32'(flag_c),      32'd0);
        chk({tag, " issue_ready"}, 32'(issue_ready), 32'd1);
    endtask

    initial begin
        int wr_at;
        int pulses;

        tbl[0]  = '{3'd0, 2'd1, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0}; // ADD carry out
        tbl[1]  = '{3'd1, 2'd0, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1}; // SUB equal
        tbl[2]  = '{3'd1, 2'd3, 8'h03, 8'h04, 8'hFF, 1'b1, 1'b0}; // SUB borrow
        tbl[3]  = '{3'd2, 2'd2, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0}; // AND, c held
        tbl[4]  = '{3'd3, 2'd1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1}; // OR zero
        tbl[5]  = '{3'd4, 2'd2, 8'hAA, 8'h55, 8'hFF, 1'b1, 1'b0}; // XOR
        tbl[6]  = '{3'd6, 2'd3, 8'h5A, 8'h00, 8'h5A, 1'b1, 1'b0}; // SHR by 0
        tbl[7]  = '{3'd5, 2'd0, 8'h00, 8'h08, 8'h00, 1'b1, 1'b1}; // SHL, rt[2:0]=0
        tbl[8]  = '{3'd0, 2'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1}; // ADD wrap
        tbl[9]  = '{3'd1, 2'd2, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0}; // SUB no borrow
        tbl[10] = '{3'd0, 2'd3, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0}; // ADD no carry

        rst_n = 1'b0; issue_valid = 1'b0; op = '0; rd = '0;
        rs_drv = '0; rt_val = '0; use_rf = 1'b0; rs_sel = '0;
        for (int i = 0; i < 4; i++) rf[i] = '0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Back-to-back single-cycle ops: one write pulse per accept
        for (int i = 0; i < 11; i++) begin
            issue(tbl[i].op, tbl[i].rd, tbl[i].a, tbl[i].b);
            chk($sformatf("vec%0d is_write", i),  32'(is_write),  32'd1);
            chk($sformatf("vec%0d reg_write", i), 32'(reg_write), 32'(tbl[i].rd));
            chk($sformatf("vec%0d write_val", i), 32'(write_val), 32'(tbl[i].val));
            chk($sformatf("vec%0d flag_c", i),    32'(flag_c),    32'(tbl[i].c));
            chk($sformatf("vec%0d flag_z", i),    32'(flag_z),    32'(tbl[i].z));
            chk($sformatf("vec%0d ready", i),     32'(issue_ready), 32'd1);
        end
        @(negedge clk);
        issue_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle is_write", 32'(is_write), 32'd0);
        chk("idle hold val", 32'(write_val), 32'h80);
        chk("idle hold reg", 32'(reg_write), 32'd3);

        // SHL 0x81 by 3, with an ADD held by upstream while busy
        issue(3'd5, 2'd1, 8'h81, 8'h03);
        @(negedge clk);
        op = 3'd0; rd = 2'd2; rs_drv = 8'h01; rt_val = 8'h02;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            chk($sformatf("shl N+%0d is_write", i), 32'(is_write), 32'd0);
            chk($sformatf("shl N+%0d busy", i),     32'(busy),     32'd1);
            chk($sformatf("shl N+%0d ready", i),    32'(issue_ready), 32'd0);
        end
        @(posedge clk); #1;
        chk("shl wr", 32'(is_write), 32'd1);
        chk("shl val", 32'(write_val), 32'h08);
        chk("shl reg", 32'(reg_write), 32'd1);
        chk("shl busy end", 32'(busy), 32'd0);
        chk("shl ready end", 32'(issue_ready), 32'd1);
        @(posedge clk); #1;
        chk("held add wr", 32'(is_write), 32'd1);
        chk("held add val", 32'(write_val), 32'h03);
        chk("held add reg", 32'(reg_write), 32'd2);
        chk("held add c", 32'(flag_c), 32'd0);
        @(negedge clk);
        issue_valid = 1'b0;

        // MUL 0x0D * 0x13 = 0xF7; operands changed after accept
        issue(3'd7, 2'd1, 8'h0D, 8'h13);
        @(negedge clk);
        issue_valid = 1'b0; rs_drv = 8'h00; rt_val = 8'h00;
        wr_at = -1; pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (is_write) begin
                pulses++;
                if (wr_at < 0) wr_at = i;
            end
        end
        chk("mul latency", 32'(wr_at), 32'd8);
        chk("mul pulses", 32'(pulses), 32'd1);
        chk("mul val", 32'(write_val), 32'hF7);
        chk("mul reg", 32'(reg_write), 32'd1);
        chk("mul z", 32'(flag_z), 32'd0);

        // Async reset in the middle of a MUL discards it
        issue(3'd7, 2'd2, 8'hFF, 8'hFF);
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mul2 busy pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async rst");
        pulses = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (is_write) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (is_write) pulses++;
        end
        chk("discarded mul pulses", 32'(pulses), 32'd0);
        chk("post rst ready", 32'(issue_ready), 32'd1);
        issue(3'd0, 2'd1, 8'h01, 8'h01);
        chk("post rst add wr", 32'(is_write), 32'd1);
        chk("post rst add val", 32'(write_val), 32'h02);

        // Dependent chain through the register file
        issue(3'd0, 2'd2, 8'h10, 8'h05);
        chk("dep first val", 32'(write_val), 32'h15);
        @(negedge clk);
        use_rf = 1'b1; rs_sel = 2'd2; op = 3'd0; rd = 2'd3; rt_val = 8'h01;
        @(posedge clk); #1;
        chk("dep second wr", 32'(is_write), 32'd1);
        chk("dep second val", 32'(write_val), 32'h16);
        @(negedge clk);
        issue_valid = 1'b0; use_rf = 1'b0;
        @(negedge clk);
        chk("dep rf r3", 32'(rf[3]), 32'h16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
